// File: rtl/cswap_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package cswap_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cswap_fs.sv
// One-bit full subtractor: d = x - y - bi, bo set when the bit borrows.
module cswap_fs (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/cswap_serial_sub.sv
// Bit-serial unsigned subtractor (LSB first, one bit per clock) with valid/ready handshakes.
// Optional signed-overflow output enabled by defining CSWAP_SUB_OVERFLOW_EN.
module cswap_serial_sub
  import cswap_pkg::*;
#(
  parameter int width = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] diff,
  output logic             bout
`ifdef CSWAP_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  state_t           state;
  logic [width-1:0] a_sh, b_sh, diff_sh;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             d, bo;

  cswap_fs u_fs (
    .x (a_sh[0]),
    .y (b_sh[0]),
    .bi(borrow),
    .d (d),
    .bo(bo)
  );

  // New difference bit enters at the MSB; after width shifts bit 0 sits in the LSB.
  generate
    if (width == 1) begin : g_w1
      assign diff_sh = d;
    end else begin : g_wn
      assign diff_sh = {d, diff[width-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      cnt       <= '0;
      borrow    <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef CSWAP_SUB_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            borrow   <= bin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          borrow <= bo;
          diff   <= diff_sh;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            bout      <= bo;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef CSWAP_SUB_OVERFLOW_EN
            // Signed overflow: borrow into the sign bit differs from borrow out of it.
            ovf       <= borrow ^ bo;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cswap_serial_sub.md
CSWAP_SERIAL_SUB -- requirements
Module: cswap_serial_sub

Interface
REQ-001 SHALL provide parameter width, default 4, operand/result bit width (legal range 1..32).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port in_valid  input  1  operand set offered.
REQ-005 SHALL provide port in_ready  output  1  block can accept operands.
REQ-006 SHALL provide ports a, b  input  width  minuend, subtrahend (unsigned).
REQ-007 SHALL provide port bin  input  1  borrow-in.
REQ-008 SHALL provide port out_valid  output  1  result available.
REQ-009 SHALL provide port out_ready  input  1  consumer accepts result.
REQ-010 SHALL provide port diff  output  width  difference.
REQ-011 SHALL provide port bout  output  1  borrow-out.

Function
REQ-012 SHALL compute diff = (a - b - bin) mod 2^width and bout = 1 iff a < b + bin (unsigned compare, width+1 bits).
REQ-013 SHALL compute bit-serially, LSB first, one bit per cycle, borrow held in a 1-bit register between cycles.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready capture a, b, bin into shift registers, clear bit counter, go RUN.
REQ-016 RUN: in_ready=0, out_valid=0; each cycle shift one difference bit into diff register and update borrow; when counter == width-1 go DONE.
REQ-017 Latency: operands accepted at edge N SHALL give out_valid=1 after edge N+width.
REQ-018 DONE: out_valid=1, diff and bout stable; on out_valid&&out_ready go IDLE; otherwise hold indefinitely.
REQ-019 in_ready SHALL be 0 in RUN and DONE; a new operand is accepted no earlier than the cycle after the result handshake.
REQ-020 in_valid and operand changes while not in IDLE SHALL be ignored.
REQ-021 width=1 SHALL work (single RUN cycle).

Reset
REQ-022 rst=1 at a rising edge SHALL force IDLE, counter=0, borrow=0, diff=0, bout=0, out_valid=0; in_ready=1 from the following cycle.
REQ-023 Reset during RUN or DONE SHALL abort the operation; no result SHALL be presented.
REQ-024 rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-025 Macro CSWAP_SUB_OVERFLOW_EN defined: SHALL add output ovf (1 bit), signed two's-complement overflow of a - b - bin, valid with out_valid, reset to 0.
REQ-026 Macro not defined: port ovf and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package cswap_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default width constant.
REQ-028 The per-bit stage SHALL be sub-module cswap_fs (full subtractor: inputs x, y, bi; outputs d, bo), instantiated once.
REQ-029 No combinational path from in_valid or out_ready to any output other than via registered state.

Verification (width=4)
REQ-030 a=5,b=3,bin=0 accepted edge N -> out_valid after edge N+4, diff=2, bout=0.
REQ-031 a=3,b=5,bin=0 -> diff=14, bout=1; a=0,b=0,bin=1 -> diff=15, bout=1; a=15,b=15,bin=0 -> diff=0, bout=0.
REQ-032 Hold out_ready=0 for 10 cycles after out_valid -> diff/bout/out_valid stable, in_ready=0; pulse out_ready -> IDLE next cycle, in_ready=1.
REQ-033 Assert rst 2 cycles into RUN -> next cycle out_valid=0, diff=0, in_ready=1; following operand a=9,b=4 yields diff=5, bout=0.
REQ-034 Toggle in_valid with new operands during RUN -> result still matches first operand set.
REQ-035 With CSWAP_SUB_OVERFLOW_EN: a=8,b=1,bin=0 -> diff=7, bout=0, ovf=1; a=7,b=1 -> ovf=0.
